// File: rtl/axis_sa_pkg.sv
// Shared constants, lane types and the saturation helper for the
// systolic-array requantiser.
package axis_sa_pkg;

    localparam int R_DEF  = 4;
    localparam int WY_DEF = 16;
    localparam int WO_DEF = 8;
    localparam int P_DEF  = 2;
    localparam int WS_DEF = 4;

    typedef logic signed [WY_DEF-1:0] lane_in_t;
    typedef logic signed [WO_DEF-1:0] lane_out_t;

    // Clamp a signed value into the signed range of a wo-bit result.
    // Values wider than 32 bits are not expected here (WY+1 <= 32).
    function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int wo);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (wo - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (wo - 1));
        if (v > hi)      sat = hi;
        else if (v < lo) sat = lo;
        else             sat = v;
    endfunction

endpackage

// File: rtl/axis_sa_requant_lane.sv
// One requantisation lane: arithmetic right shift in WY+1 bits, optional
// round-half-up, then saturation to WO bits. Purely combinational.
// Build option: AXIS_SA_REQUANT_ROUND_EN enables rounding; otherwise the
// shift truncates toward minus infinity.
module requant_lane
    import axis_sa_pkg::*;
#(
    parameter int WY = WY_DEF,
    parameter int WO = WO_DEF,
    parameter int WS = WS_DEF
) (
    input  logic [WY-1:0] x_i,
    input  logic [WS-1:0] shift_i,
    output logic [WO-1:0] y_o
);

    localparam int W1 = WY + 1;

    logic signed [W1-1:0] ext;
    logic signed [W1-1:0] rnd;
    logic signed [W1-1:0] sh;

    // Sign-extend by one bit so the rounding add can never wrap, then shift and saturate.
    always_comb begin
        ext = {x_i[WY-1], x_i};
        rnd = '0;
`ifdef AXIS_SA_REQUANT_ROUND_EN
        if (shift_i != '0) rnd = W1'(1) <<< (shift_i - WS'(1));
`else
        rnd = '0;
`endif
        sh  = (ext + rnd) >>> shift_i;
        y_o = WO'(sat(32'(sh), WO));
    end

endmodule

// File: rtl/axis_sa_requant.sv
// AXI-Stream requantiser for systolic-array result columns. Each accepted
// R-lane beat is held and emitted as R/P consecutive P-lane slices, each lane
// shifted right by a per-packet shift and saturated to WO bits.
// Build option: AXIS_SA_REQUANT_ROUND_EN (see requant_lane) selects
// round-half-up instead of truncation.
module axis_sa_requant
    import axis_sa_pkg::*;
#(
    parameter int R  = R_DEF,
    parameter int WY = WY_DEF,
    parameter int WO = WO_DEF,
    parameter int P  = P_DEF,
    parameter int WS = WS_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 s_last,
    input  logic [R-1:0][WY-1:0] s_data,
    input  logic [WS-1:0]        shift_amt,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic [P-1:0][WO-1:0] m_data
);

    localparam int NS = R / P;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    logic [R-1:0][WY-1:0] hold_q, hold_d;
    logic                 last_q, last_d;
    logic                 held_q, held_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 first_q, first_d;
    logic [WS-1:0]        shift_q, shift_d;

    logic                 last_slice;
    logic                 accept;
    logic                 m_fire;
    logic [P-1:0][WY-1:0] slice;

    assign last_slice = (idx_q == IW'(NS - 1));
    // Ready when empty, or when the final slice leaves this cycle: back-to-back beats reload without a bubble.
    assign s_ready    = !held_q || (m_ready && last_slice);
    assign accept     = s_valid && s_ready;
    assign m_fire     = held_q && m_ready;
    assign m_valid    = held_q;
    assign m_last     = held_q && last_q && last_slice;

    // Next-state: slice advance on output handshake, reload on input handshake.
    always_comb begin
        hold_d  = hold_q;
        last_d  = last_q;
        held_d  = held_q;
        idx_d   = idx_q;
        first_d = first_q;
        shift_d = shift_q;
        if (m_fire) begin
            if (last_slice) begin
                held_d = 1'b0;
                idx_d  = '0;
            end else begin
                idx_d  = idx_q + IW'(1);
            end
        end
        if (accept) begin
            hold_d  = s_data;
            last_d  = s_last;
            held_d  = 1'b1;
            idx_d   = '0;
            first_d = s_last;
            // Shift is only sampled on a packet's first beat; oversize values clamp to WY-1.
            if (first_q) begin
                if (int'(shift_amt) >= WY) shift_d = WS'(WY - 1);
                else                       shift_d = shift_amt;
            end
        end
    end

    // State registers; reset drops any held beat so nothing stale is emitted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_q  <= '0;
            last_q  <= 1'b0;
            held_q  <= 1'b0;
            idx_q   <= '0;
            first_q <= 1'b1;
            shift_q <= '0;
        end else begin
            hold_q  <= hold_d;
            last_q  <= last_d;
            held_q  <= held_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            shift_q <= shift_d;
        end
    end

    // Select lanes idx*P .. idx*P+P-1 of the held beat for the current slice.
    always_comb begin
        slice = '0;
        for (int s = 0; s < NS; s++) begin
            if (idx_q == IW'(s)) begin
                for (int p = 0; p < P; p++) slice[p] = hold_q[s*P + p];
            end
        end
    end

    for (genvar p = 0; p < P; p++) begin : g_lane
        requant_lane #(.WY(WY), .WO(WO), .WS(WS)) u_lane (
            .x_i     (slice[p]),
            .shift_i (shift_q),
            .y_o     (m_data[p])
        );
    end

endmodule

// File: doc/axis_sa_requant.md
AXIS_SA_REQUANT -- requirements
Module: axis_sa_requant

Interface
REQ-001 SHALL have parameter R, default 4: number of accumulator lanes per input beat.
REQ-002 SHALL have parameter WY, default 16: signed input lane width.
REQ-003 SHALL have parameter WO, default 8: signed output lane width; WO < WY.
REQ-004 SHALL have parameter P, default 2: lanes per output beat; R % P == 0.
REQ-005 SHALL have parameter WS, default 4: width of the shift amount.
REQ-006 SHALL have port clk, input, 1: the single clock.
REQ-007 SHALL have port rstn, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port s_valid / s_ready / s_last, input / output / input, 1 each: AXIS slave handshake.
REQ-009 SHALL have port s_data, input, [R-1:0][WY-1:0]: the systolic array result column.
REQ-010 SHALL have port shift_amt, input, WS: right-shift amount, sampled per packet.
REQ-011 SHALL have port m_valid / m_ready / m_last, output / input / output, 1 each: AXIS master handshake.
REQ-012 SHALL have port m_data, output, [P-1:0][WO-1:0]: requantised lane slice.

Function
REQ-013 SHALL capture s_data and s_last into a hold register on s_valid && s_ready.
REQ-014 SHALL maintain a slice counter idx covering 0..R/P-1; the output beat carries lanes idx*P .. idx*P+P-1, with lane idx*P in m_data[0].
REQ-015 SHALL assert m_valid exactly 1 cycle after input acceptance, and hold it until the final slice is accepted.
REQ-016 SHALL advance idx on m_valid && m_ready, and wrap it to 0 after slice R/P-1.
REQ-017 SHALL drive s_ready = !held || (m_ready && idx == R/P-1), so a full pipe reloads with no bubble.
REQ-018 SHALL hold m_data, m_last and idx stable while m_valid && !m_ready.
REQ-019 SHALL assert m_last only on the final slice of a held beat whose s_last was 1.
REQ-020 SHALL latch shift_amt on the first accepted beat of each packet (after reset, or after a beat with s_last=1), and ignore changes mid-packet.
REQ-021 SHALL clamp a latched shift value of WY or more to WY-1.
REQ-022 SHALL compute each lane as an arithmetic right shift in WY+1 bits, so that rounding cannot overflow.
REQ-023 SHALL saturate each lane result to [-2^(WO-1), 2^(WO-1)-1].
REQ-024 SHALL perform no arithmetic on the output path beyond this combinational requantisation of the held slice.

Reset
REQ-025 SHALL, while rstn=0, clear the hold register, idx, the held flag and the latched shift, with the first-beat flag set to 1.
REQ-026 SHALL drive m_valid=0, m_last=0, m_data=0 and s_ready=1 after reset.
REQ-027 SHALL, on reset mid-packet, discard any held beat without emitting it; the next accepted beat starts a new packet.

Configuration
REQ-028 SHALL, with AXIS_SA_REQUANT_ROUND_EN defined, round half-up by adding 2^(shift-1) before shifting when shift > 0.
REQ-029 SHALL, without AXIS_SA_REQUANT_ROUND_EN, truncate (floor) with no rounding add; saturation is unchanged.

Structure
REQ-030 SHALL place the default parameter constants, the lane typedefs and a saturate function in the shared package axis_sa_pkg.
REQ-031 SHALL instantiate P copies of the sub-module requant_lane, a combinational shift/round/saturate for one lane.

Verification (R=4, P=2, WY=16, WO=8)
REQ-032 SHALL cover: shift=4, lanes {256, 24, -24, 32767}, ROUND_EN defined -> beat0 {16, 2}, beat1 {-1, 127}; without the macro -> {16, 1}, {-2, 127}.
REQ-033 SHALL cover: shift=0, lanes {-300, 200, -128, 127} -> {-128, 127}, {-128, 127}.
REQ-034 SHALL cover: a 3-beat packet with m_ready held 1 -> 6 contiguous output beats, m_last only on beat 6, and s_ready never low for more than 1 cycle per input beat.
REQ-035 SHALL cover: m_ready=0 for 5 cycles mid-slice -> m_data/m_last stable, s_ready=0 and no input accepted.
REQ-036 SHALL cover: shift_amt changed from 4 to 2 during beat 2 of a packet -> shift 4 still applied, shift 2 applied from the next packet's first beat.
REQ-037 SHALL cover: rstn pulsed low while slice 1 is pending -> m_valid=0 within the same cycle, s_ready=1, and no stale slice emitted afterwards.
